// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Included by div_step and div_seq.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } div_state_t;

    // Quotient reported for a zero divisor; sliced to the operand width by users.
    localparam logic [63:0] DIV0_QUOT = '1;

    // Iteration counter width: holds 0..W without wrapping.
    function automatic int ctr_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor.
// Purely combinational; no latency, no backpressure.
module div_step
    import div_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0]   rem_sh;
    logic [W+1:0] trial;
    logic         neg;

    always_comb begin
        rem_sh  = {rem_in, quo_in[W-1]};
        trial   = {1'b0, rem_sh} - {2'b00, divisor};
        neg     = trial[W+1];
        // rem_in < divisor keeps both the restored and the subtracted value within W bits
        rem_out = neg ? rem_sh[W-1:0] : trial[W-1:0];
        quo_out = {quo_in[W-2:0], ~neg};
    end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider y=a/b (r=a%b with DIV_REM_EN), one quotient bit per clock.
// Latency W cycles from accepted start (1 cycle for b==0); start ignored unless idle.
module div_seq
    import div_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a_bi,
    input  logic [W-1:0] b_bi,
    input  logic         start,
    output logic         busy_o,
    output logic [W-1:0] y_bo,
`ifdef DIV_REM_EN
    output logic [W-1:0] r_bo,
`endif
    output logic         out_ready
);

    localparam int CW = ctr_w(W);

    div_state_t    state_q, state_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  y_q, y_d;
    logic          rdy_q, rdy_d;
    logic          div0_q, div0_d;
    logic [W-1:0]  step_rem, step_quo;
`ifdef DIV_REM_EN
    logic [W-1:0]  r_q, r_d;
`endif

    div_step #(.W(W)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        y_d     = y_q;
        rdy_d   = 1'b0;
        div0_d  = 1'b0;
`ifdef DIV_REM_EN
        r_d     = r_q;
`endif
        case (state_q)
            IDLE: begin
                if (div0_q) begin
                    // Zero divisor: dividend was parked in quo_q one cycle earlier
                    y_d   = DIV0_QUOT[W-1:0];
                    rdy_d = 1'b1;
`ifdef DIV_REM_EN
                    r_d   = quo_q;
`endif
                end else if (start) begin
                    dvs_d = b_bi;
                    quo_d = a_bi;
                    rem_d = '0;
                    ctr_d = '0;
                    if (b_bi == '0) begin
                        div0_d = 1'b1;
                    end else begin
                        state_d = WORK;
                    end
                end
            end
            WORK: begin
                rem_d = step_rem;
                quo_d = step_quo;
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == CW'(W - 1)) begin
                    y_d     = step_quo;
                    rdy_d   = 1'b1;
                    ctr_d   = '0;
                    state_d = IDLE;
`ifdef DIV_REM_EN
                    r_d     = step_rem;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            y_q     <= '0;
            rdy_q   <= 1'b0;
            div0_q  <= 1'b0;
`ifdef DIV_REM_EN
            r_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            y_q     <= y_d;
            rdy_q   <= rdy_d;
            div0_q  <= div0_d;
`ifdef DIV_REM_EN
            r_q     <= r_d;
`endif
        end
    end

    assign busy_o    = (state_q == WORK);
    assign y_bo      = y_q;
    assign out_ready = rdy_q;
`ifdef DIV_REM_EN
    assign r_bo      = r_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq (W=16) against a reference division model.
// Builds with or without DIV_REM_EN; remainder checks follow the build.
module tb_div_seq;

    localparam int W = 16;
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a_bi, b_bi;
    logic         start;
    logic         busy_o;
    logic [W-1:0] y_bo;
    logic         out_ready;
`ifdef DIV_REM_EN
    logic [W-1:0] r_bo;
`endif

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div_seq #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_bi      (a_bi),
        .b_bi      (b_bi),
        .start     (start),
        .busy_o    (busy_o),
        .y_bo      (y_bo),
`ifdef DIV_REM_EN
        .r_bo      (r_bo),
`endif
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.y = {W{1'b1}};
            e.r = a;
        end else begin
            e.y = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic get_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_y"}, {16'd0, y_bo}, {16'd0, e.y});
`ifdef DIV_REM_EN
            chk({tag, "_r"}, {16'd0, r_bo}, {16'd0, e.r});
`endif
        end
    endtask

    // Issue one op; optionally pulse a competing start ign_at cycles into it.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input int exp_busy, input int ign_at);
        int lat;
        int busy_cnt;
        @(negedge clk);
        a_bi = a; b_bi = b; start = 1'b1;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = int'(busy_o);
        while (!out_ready && lat < TMO) begin
            @(negedge clk);
            lat++;
            if (ign_at != 0 && lat == ign_at) begin
                a_bi = 16'd9; b_bi = 16'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!out_ready) busy_cnt += int'(busy_o);
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, busy_cnt, exp_busy);
        get_result(tag);
        @(negedge clk);
        chk({tag, "_rdy_drop"}, {31'd0, out_ready}, 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b0; a_bi = '0; b_bi = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_y", {16'd0, y_bo}, 32'd0);
        chk("rst_rdy", {31'd0, out_ready}, 32'd0);
`ifdef DIV_REM_EN
        chk("rst_r", {16'd0, r_bo}, 32'd0);
`endif
        reset = 1'b0;

        run_op("d100_7", 16'd100, 16'd7, 16, 16, 0);
        run_op("ffff_1", 16'hFFFF, 16'd1, 16, 16, 0);
        run_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 16, 16, 0);
        run_op("div0", 16'd5, 16'd0, 1, 0, 0);
        run_op("a_lt_b_ign", 16'd3, 16'd10, 16, 16, 5);

        // Abandon an op by reset at step 8; outputs must clear without waiting for a clock.
        @(negedge clk);
        a_bi = 16'd1000; b_bi = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_y", {16'd0, y_bo}, 32'd0);
        chk("mid_rst_rdy", {31'd0, out_ready}, 32'd0);
`ifdef DIV_REM_EN
        chk("mid_rst_r", {16'd0, r_bo}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(out_ready);
        end
        chk("abandoned_no_rdy", n, 0);
        run_op("d1000_3", 16'd1000, 16'd3, 16, 16, 0);

        // Held start re-issues one op every W+1 cycles.
        @(negedge clk);
        a_bi = 16'd50; b_bi = 16'd5; start = 1'b1;
        exp_q.push_back(model(16'd50, 16'd5));
        exp_q.push_back(model(16'd50, 16'd5));
        n = 0;
        while (!out_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("hold_first_lat", n, 17);
        get_result("hold1");
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!out_ready && gap < TMO);
        start = 1'b0;
        chk("hold_gap", gap, W + 1);
        get_result("hold2");
        repeat (2) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = (i % 4 == 0) ? W'($urandom_range(1, 20)) : W'($urandom_range(1, 65535));
            run_op("rand", ra, rb, 16, 16, 0);
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
